// File: rtl/f_pc_ctrl_pkg.sv
// Shared constants for the fetch-stage PC controller: jump-class encodings,
// fixed addresses and the fetch address-error exception code.
package f_pc_ctrl_pkg;

    typedef enum logic [1:0] {
        NPC_PC4    = 2'd0,
        NPC_BRANCH = 2'd1,
        NPC_J      = 2'd2,
        NPC_JR     = 2'd3
    } npc_op_e;

    localparam logic [31:0] PC_RESET  = 32'h0000_3000;
    localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
    localparam logic [31:0] IM_LO     = 32'h0000_3000;
    localparam logic [31:0] IM_HI     = 32'h0000_6FFC;

    localparam logic [4:0] EXC_CODE_ADEL = 5'd4;

    function automatic logic fetch_addr_bad(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr < IM_LO) || (addr > IM_HI);
    endfunction

endpackage

// File: rtl/f_npc_sel.sv
// Next-PC target arithmetic and selection for the normal (non-exception,
// non-stalled) path. All additions wrap modulo 2^32.
module f_npc_sel
    import f_pc_ctrl_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  npc_op,
    input  logic        b_jump,
    input  logic [31:0] D_pc,
    input  logic [15:0] D_imm16,
    input  logic [25:0] D_imm26,
    input  logic [31:0] D_rs,
    output logic [31:0] npc
);

    logic [31:0] pc_plus4;
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;

    assign pc_plus4 = pc + 32'd4;
    assign br_tgt   = D_pc + 32'd4 + {{14{D_imm16[15]}}, D_imm16, 2'b00};
    assign j_tgt    = {D_pc[31:28], D_imm26, 2'b00};

    // b_jump is only looked at inside the BRANCH arm so an undriven value
    // from the comparator cannot leak into the PC for other jump classes.
    always_comb begin
        npc = pc_plus4;
        case (npc_op)
            NPC_BRANCH: npc = b_jump ? br_tgt : pc_plus4;
            NPC_J:      npc = j_tgt;
            NPC_JR:     npc = D_rs;
            default:    npc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/f_pc_ctrl.sv
// Fetch-stage PC register with delay-slot flag; resolves exception entry,
// eret and stall priority ahead of the normal next-PC selection.
module f_pc_ctrl
    import f_pc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  npc_op,
    input  logic        b_jump,
    input  logic [31:0] D_pc,
    input  logic [15:0] D_imm16,
    input  logic [25:0] D_imm26,
    input  logic [31:0] D_rs,
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic [31:0] F_pc,
    output logic        F_bd,
    output logic        F_exc_adel
);

    logic [31:0] pc;
    logic        bd;
    logic [31:0] npc;

    f_npc_sel u_npc_sel (
        .pc      (pc),
        .npc_op  (npc_op),
        .b_jump  (b_jump),
        .D_pc    (D_pc),
        .D_imm16 (D_imm16),
        .D_imm26 (D_imm26),
        .D_rs    (D_rs),
        .npc     (npc)
    );

    // Exception entry beats a stall, but eret waits for the stall to clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= PC_RESET;
            bd <= 1'b0;
        end else if (exc_req) begin
            pc <= EXC_ENTRY;
            bd <= 1'b0;
        end else if (stall) begin
            pc <= pc;
            bd <= bd;
        end else if (eret) begin
            pc <= epc;
            bd <= 1'b0;
        end else begin
            pc <= npc;
            bd <= (npc_op != NPC_PC4);
        end
    end

    assign F_pc       = pc;
    assign F_bd       = bd;
    assign F_exc_adel = fetch_addr_bad(pc);

endmodule

// File: tb/tb_f_pc_ctrl.sv
// Testbench for f_pc_ctrl: directed scenarios followed by randomized traffic,
// all checked against a behavioural next-PC model.
module tb_f_pc_ctrl;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [1:0]  npc_op;
    logic        b_jump;
    logic [31:0] D_pc;
    logic [15:0] D_imm16;
    logic [25:0] D_imm26;
    logic [31:0] D_rs;
    logic        exc_req;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] F_pc;
    logic        F_bd;
    logic        F_exc_adel;

    int check_count = 0;
    int pass_count  = 0;

    logic [31:0] m_pc;
    logic        m_bd;

    f_pc_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .npc_op     (npc_op),
        .b_jump     (b_jump),
        .D_pc       (D_pc),
        .D_imm16    (D_imm16),
        .D_imm26    (D_imm26),
        .D_rs       (D_rs),
        .exc_req    (exc_req),
        .eret       (eret),
        .epc        (epc),
        .F_pc       (F_pc),
        .F_bd       (F_bd),
        .F_exc_adel (F_exc_adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed === expected)
            pass_count++;
        else
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    endtask

    // Reference: the next fetch address written straight from the priority rules.
    function automatic void model_next();
        longint br;
        if (reset) begin
            m_pc = 32'h3000; m_bd = 1'b0;
        end else if (exc_req) begin
            m_pc = 32'h4180; m_bd = 1'b0;
        end else if (stall) begin
            m_pc = m_pc;
        end else if (eret) begin
            m_pc = epc; m_bd = 1'b0;
        end else begin
            m_bd = (npc_op != 2'd0);
            if (npc_op == 2'd1 && b_jump == 1'b1) begin
                br   = longint'(D_pc) + 4 + 4 * longint'($signed(D_imm16));
                m_pc = br[31:0];
            end else if (npc_op == 2'd2)
                m_pc = (D_pc & 32'hF000_0000) | (32'(D_imm26) * 32'd4);
            else if (npc_op == 2'd3)
                m_pc = D_rs;
            else
                m_pc = m_pc + 32'd4;
        end
    endfunction

    function automatic logic model_adel(input logic [31:0] a);
        return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h6FFC);
    endfunction

    task automatic applyStimulus(input string tag);
        model_next();
        @(posedge clk);
        #1;
        checkOutput({tag, "_pc"}, F_pc, m_pc);
        checkOutput({tag, "_bd"}, 32'(F_bd), 32'(m_bd));
        checkOutput({tag, "_adel"}, 32'(F_exc_adel), 32'(model_adel(m_pc)));
    endtask

    task automatic idle_inputs();
        reset = 1'b0; stall = 1'b0; npc_op = 2'd0; b_jump = 1'b0;
        D_pc = 32'h0; D_imm16 = 16'h0; D_imm26 = 26'h0; D_rs = 32'h0;
        exc_req = 1'b0; eret = 1'b0; epc = 32'h0;
    endtask

    initial begin
        idle_inputs();
        m_pc = 32'h0;
        m_bd = 1'b0;

        // 1: reset then sequential fetch
        reset = 1'b1;
        applyStimulus("rst0");
        applyStimulus("rst1");
        checkOutput("rst_lit", F_pc, 32'h3000);
        reset = 1'b0;
        applyStimulus("seq0");
        checkOutput("seq0_lit", F_pc, 32'h3004);
        applyStimulus("seq1");
        checkOutput("seq1_lit", F_pc, 32'h3008);

        // 2: taken and not-taken branch
        npc_op = 2'd1; D_pc = 32'h3010; D_imm16 = 16'hFFFC; b_jump = 1'b1;
        applyStimulus("br_taken");
        checkOutput("br_taken_lit", F_pc, 32'h3004);
        checkOutput("br_taken_bd", 32'(F_bd), 32'd1);
        b_jump = 1'b0;
        applyStimulus("br_not");
        checkOutput("br_not_lit", F_pc, 32'h3008);

        // 3: J and misaligned JR
        npc_op = 2'd2; D_pc = 32'h3020; D_imm26 = 26'h0000C40;
        applyStimulus("j");
        checkOutput("j_lit", F_pc, 32'h3100);
        npc_op = 2'd3; D_rs = 32'h3202;
        applyStimulus("jr");
        checkOutput("jr_adel", 32'(F_exc_adel), 32'd1);

        // 4: stalled jump is applied exactly once
        npc_op = 2'd2; D_pc = 32'h3020; D_imm26 = 26'h0000C80; stall = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus("stall");
        checkOutput("stall_hold", F_pc, 32'h3202);
        stall = 1'b0;
        applyStimulus("stall_rel");
        checkOutput("stall_rel_lit", F_pc, 32'h3200);
        npc_op = 2'd0;
        applyStimulus("after_j");

        // 5: exception overrides stall and eret
        stall = 1'b1; exc_req = 1'b1;
        applyStimulus("exc_stall");
        checkOutput("exc_stall_lit", F_pc, 32'h4180);
        stall = 1'b0; eret = 1'b1; epc = 32'h3058;
        applyStimulus("exc_eret");
        exc_req = 1'b0; stall = 1'b1;
        applyStimulus("eret_stalled");
        checkOutput("eret_stalled_lit", F_pc, 32'h4180);

        // 6: eret, then reset during a branch
        stall = 1'b0;
        applyStimulus("eret");
        checkOutput("eret_lit", F_pc, 32'h3058);
        eret = 1'b0; npc_op = 2'd1; b_jump = 1'b1; D_pc = 32'h3400; D_imm16 = 16'h0010;
        reset = 1'b1;
        applyStimulus("rst_mid_br");
        checkOutput("rst_mid_br_lit", F_pc, 32'h3000);
        reset = 1'b0;

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            reset   = ($urandom_range(0, 63) == 0);
            exc_req = ($urandom_range(0, 19) == 0);
            eret    = ($urandom_range(0, 14) == 0);
            stall   = ($urandom_range(0, 4) == 0);
            npc_op  = 2'($urandom_range(0, 3));
            b_jump  = 1'($urandom_range(0, 1));
            D_pc    = ($urandom_range(0, 7) == 0) ? 32'($urandom)
                                                   : 32'h3000 + 32'($urandom_range(0, 4095)) * 4;
            D_imm16 = 16'($urandom);
            D_imm26 = 26'($urandom);
            D_rs    = ($urandom_range(0, 3) == 0) ? 32'($urandom)
                                                   : 32'h3000 + 32'($urandom_range(0, 4095)) * 4;
            epc     = 32'h3000 + 32'($urandom_range(0, 4095)) * 4;
            applyStimulus("rand");
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
